weight_bank_loader: RTL and testbench



---
 rtl/weight_bank_loader.sv | 221 ++++++++++++++++++++++
 tb/tb_weight_bank_loader.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_bank_loader.sv
// weight_bank_loader: double-buffered kernel-weight loader for the conv PE array.
// Filters are read channel by channel from a synchronous ROM into a shadow bank
// while the active bank drives the PE weights; banks swap on fmap_finish.
module weight_bank_loader #(
   parameter int unsigned M           = 8,
   parameter int unsigned TAPS        = 9,
   parameter int unsigned CH          = 2,
   parameter int unsigned NUM_FILTERS = 8,
   parameter int unsigned ROM_LAT     = 1,
   parameter int unsigned AW          = 8
) (
   input  logic                 clk,
   input  logic                 Rst_n,
   input  logic                 start,
   input  logic                 fmap_finish,
   output logic                 rom_rd_en,
   output logic [AW-1:0]        rom_addr,
   input  logic [TAPS*M-1:0]    rom_rd_data,
   output logic [CH*TAPS*M-1:0] weights,
   output logic                 weights_valid,
   output logic [7:0]           filter_count,
   output logic                 filter_finish,
   output logic                 busy
);

   localparam int unsigned CW         = (CH > 1) ? $clog2(CH) : 1;
   localparam logic [CW-1:0] LastCh   = CW'(CH - 1);
   localparam logic [7:0] LastFilter  = 8'(NUM_FILTERS - 1);
   localparam logic [8:0] NumFilters  = 9'(NUM_FILTERS);

   typedef enum logic [1:0] {StIdle, StFetch, StHold} state_e;

   // Tag travelling alongside an outstanding ROM read.
   typedef struct packed {
      logic          vld;
      logic [CW-1:0] idx;
   } tag_t;

   state_e            state_q, state_d;
   logic              rom_rd_en_q, rom_rd_en_d;
   logic [AW-1:0]     rom_addr_q, rom_addr_d;
   logic [CW-1:0]     ch_q, ch_d;
   logic [7:0]        fetch_idx_q, fetch_idx_d;
   logic              pending_q, pending_d;
   logic              weights_valid_q, weights_valid_d;
   logic [7:0]        filter_count_q, filter_count_d;
   logic              filter_finish_q, filter_finish_d;
   logic              busy_q, busy_d;
   logic [TAPS*M-1:0] shadow_q [CH];
   logic [TAPS*M-1:0] shadow_d [CH];
   logic [TAPS*M-1:0] shadow_m [CH];
   logic [TAPS*M-1:0] active_q [CH];
   logic [TAPS*M-1:0] active_d [CH];
   tag_t              tag_q [ROM_LAT];
   tag_t              tag_d [ROM_LAT];

   logic [TAPS*M-1:0] word_u;
   logic              tag_hit;
   logic              last_word;
   logic              more_filters;
   logic              do_swap;

   // ROM word has tap 0 in the MSBs; re-pack so tap t sits at [t*M +: M].
   for (genvar t = 0; t < TAPS; t++) begin : g_unpack
      assign word_u[t*M +: M] = rom_rd_data[(TAPS-t)*M-1 -: M];
   end

   assign tag_hit      = tag_q[ROM_LAT-1].vld;
   assign last_word    = tag_hit && (tag_q[ROM_LAT-1].idx == LastCh);
   assign more_filters = ({1'b0, fetch_idx_q} + 9'd1) < NumFilters;

   // Shadow bank with the word returning this cycle merged in, so the last
   // channel can be swapped straight into the active bank on its capture edge.
   always_comb begin
      shadow_m = shadow_q;
      if (tag_hit) begin
         shadow_m[tag_q[ROM_LAT-1].idx] = word_u;
      end
   end

   // Next-state logic: read issue, tag pipeline, bank control FSM.
   always_comb begin
      state_d         = state_q;
      rom_rd_en_d     = rom_rd_en_q;
      rom_addr_d      = rom_addr_q;
      ch_d            = ch_q;
      fetch_idx_d     = fetch_idx_q;
      pending_d       = pending_q;
      weights_valid_d = weights_valid_q;
      filter_count_d  = filter_count_q;
      filter_finish_d = 1'b0;
      shadow_d        = shadow_q;
      active_d        = active_q;
      do_swap         = 1'b0;

      tag_d[0] = '{vld: rom_rd_en_q, idx: ch_q};
      for (int i = 1; i < ROM_LAT; i++) begin
         tag_d[i] = tag_q[i-1];
      end

      if (tag_hit) begin
         shadow_d = shadow_m;
      end

      // Reads run back to back, so the address simply advances by one word.
      if (rom_rd_en_q) begin
         if (ch_q == LastCh) begin
            rom_rd_en_d = 1'b0;
         end else begin
            ch_d       = ch_q + CW'(1);
            rom_addr_d = rom_addr_q + AW'(1);
         end
      end

      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d     = StFetch;
               fetch_idx_d = 8'd0;
               rom_rd_en_d = 1'b1;
               rom_addr_d  = '0;
               ch_d        = '0;
            end
         end
         StFetch: begin
            if (last_word) begin
               // An fmap_finish coinciding with the last word swaps at once.
               if (!weights_valid_q || pending_q || fmap_finish) begin
                  do_swap = 1'b1;
               end else begin
                  state_d = StHold;
               end
            end else if (fmap_finish && weights_valid_q && !pending_q) begin
               pending_d       = 1'b1;
               weights_valid_d = 1'b0;
            end
         end
         StHold: begin
            if (fmap_finish) begin
               if (filter_count_q == LastFilter) begin
                  filter_finish_d = 1'b1;
                  weights_valid_d = 1'b0;
                  filter_count_d  = 8'd0;
                  state_d         = StIdle;
               end else begin
                  do_swap = 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      // The filter being swapped in is always the one just fetched.
      if (do_swap) begin
         active_d        = shadow_m;
         weights_valid_d = 1'b1;
         pending_d       = 1'b0;
         filter_count_d  = fetch_idx_q;
         if (more_filters) begin
            fetch_idx_d = fetch_idx_q + 8'd1;
            state_d     = StFetch;
            rom_rd_en_d = 1'b1;
            rom_addr_d  = rom_addr_q + AW'(1);
            ch_d        = '0;
         end else begin
            state_d = StHold;
         end
      end

      busy_d = (state_d != StIdle);
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q         <= StIdle;
         rom_rd_en_q     <= 1'b0;
         rom_addr_q      <= '0;
         ch_q            <= '0;
         fetch_idx_q     <= 8'd0;
         pending_q       <= 1'b0;
         weights_valid_q <= 1'b0;
         filter_count_q  <= 8'd0;
         filter_finish_q <= 1'b0;
         busy_q          <= 1'b0;
         for (int i = 0; i < CH; i++) begin
            shadow_q[i] <= '0;
            active_q[i] <= '0;
         end
         for (int i = 0; i < ROM_LAT; i++) begin
            tag_q[i] <= '0;
         end
      end else begin
         state_q         <= state_d;
         rom_rd_en_q     <= rom_rd_en_d;
         rom_addr_q      <= rom_addr_d;
         ch_q            <= ch_d;
         fetch_idx_q     <= fetch_idx_d;
         pending_q       <= pending_d;
         weights_valid_q <= weights_valid_d;
         filter_count_q  <= filter_count_d;
         filter_finish_q <= filter_finish_d;
         busy_q          <= busy_d;
         shadow_q        <= shadow_d;
         active_q        <= active_d;
         tag_q           <= tag_d;
      end
   end

   for (genvar c = 0; c < CH; c++) begin : g_pack
      assign weights[c*TAPS*M +: TAPS*M] = active_q[c];
   end

   assign rom_rd_en     = rom_rd_en_q;
   assign rom_addr      = rom_addr_q;
   assign weights_valid = weights_valid_q;
   assign filter_count  = filter_count_q;
   assign filter_finish = filter_finish_q;
   assign busy          = busy_q;

endmodule

// File: tb/tb_weight_bank_loader.sv
// Bench for weight_bank_loader: a cycle-scheduled model checks the default
// instance every cycle; ROM_LAT=3 and NUM_FILTERS=1 instances get directed checks.
module tb_weight_bank_loader;

   localparam int CH  = 2;
   localparam int LAT = 1;
   localparam int NF  = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   // Default instance
   logic         rst_n = 1'b0, start = 1'b0, ff = 1'b0;
   logic         rd, wv, fin, bsy;
   logic [7:0]   addr, fc;
   logic [71:0]  rdata;
   logic [143:0] w;
   // ROM_LAT=3 instance
   logic         rst_aux_n = 1'b0, start3 = 1'b0, ff3 = 1'b0;
   logic         rd3, wv3, fin3, bsy3;
   logic [7:0]   addr3, fc3;
   logic [71:0]  rdata3;
   logic [143:0] w3;
   logic [71:0]  r3 [3];
   // NUM_FILTERS=1 instance
   logic         start1 = 1'b0, ff1 = 1'b0;
   logic         rd1, wv1, fin1, bsy1;
   logic [7:0]   addr1, fc1;
   logic [71:0]  rdata1;
   logic [143:0] w1;

   weight_bank_loader u_dut (
      .clk(clk), .Rst_n(rst_n), .start(start), .fmap_finish(ff),
      .rom_rd_en(rd), .rom_addr(addr), .rom_rd_data(rdata), .weights(w),
      .weights_valid(wv), .filter_count(fc), .filter_finish(fin), .busy(bsy)
   );

   weight_bank_loader #(.ROM_LAT(3)) u_dut3 (
      .clk(clk), .Rst_n(rst_aux_n), .start(start3), .fmap_finish(ff3),
      .rom_rd_en(rd3), .rom_addr(addr3), .rom_rd_data(rdata3), .weights(w3),
      .weights_valid(wv3), .filter_count(fc3), .filter_finish(fin3), .busy(bsy3)
   );

   weight_bank_loader #(.NUM_FILTERS(1)) u_dut1 (
      .clk(clk), .Rst_n(rst_aux_n), .start(start1), .fmap_finish(ff1),
      .rom_rd_en(rd1), .rom_addr(addr1), .rom_rd_data(rdata1), .weights(w1),
      .weights_valid(wv1), .filter_count(fc1), .filter_finish(fin1), .busy(bsy1)
   );

   function automatic logic [71:0] rep_word(input logic [7:0] a);
      return {9{a}};
   endfunction

   function automatic logic [71:0] rom3_word(input logic [7:0] a);
      if (a == 8'd0) return 72'h010203040506070809;
      return rep_word(a);
   endfunction

   // Synchronous ROMs; unread cycles return a junk pattern.
   always @(posedge clk) begin
      rdata  <= rd  ? rep_word(addr)   : {9{8'hA5}};
      rdata1 <= rd1 ? rep_word(addr1)  : {9{8'hA5}};
      r3[0]  <= rd3 ? rom3_word(addr3) : {9{8'h5A}};
      r3[1]  <= r3[0];
      r3[2]  <= r3[1];
   end
   assign rdata3 = r3[2];

   // Filter f of the replicated-address ROM: channel c taps all equal f*CH+c.
   function automatic logic [143:0] exp_w(input int f);
      if (f < 0) return '0;
      return {rep_word(8'(2*f+1)), rep_word(8'(2*f))};
   endfunction

   task automatic chk(input string name, input logic [143:0] act, input logic [143:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Transaction-level model: a fetch issues CH reads from cycle m_rs and its
   // filter is first visible at m_ready; a consumer request swaps it in once ready.
   bit m_busy, m_valid, m_finish, m_fetch, m_first, m_wait;
   int m_count, m_widx = -1, m_fidx, m_rs, m_ready;
   int fin_pulses = 0;

   task automatic model_reset();
      m_busy = 0; m_valid = 0; m_finish = 0; m_fetch = 0; m_first = 0; m_wait = 0;
      m_count = 0; m_widx = -1; m_fidx = 0; m_rs = 0; m_ready = 0;
   endtask

   task automatic model_step(input int c, input logic st, input logic fm);
      m_finish = 0;
      if (!m_busy) begin
         if (st) begin
            m_busy = 1; m_fetch = 1; m_fidx = 0; m_rs = c; m_ready = c + CH + LAT;
            m_first = 1; m_wait = 0;
         end
      end else begin
         if (fm && m_valid) begin
            if (m_count == NF - 1) begin
               m_finish = 1; m_valid = 0; m_count = 0; m_busy = 0; m_fetch = 0;
            end else begin
               m_wait = 1;
            end
         end
         if (m_fetch && m_ready <= c && (m_first || m_wait)) begin
            m_widx = m_fidx; m_count = m_fidx; m_valid = 1; m_first = 0; m_wait = 0;
            if (m_fidx + 1 < NF) begin
               m_fidx++; m_rs = c; m_ready = c + CH + LAT;
            end else begin
               m_fetch = 0;
            end
         end else if (m_wait) begin
            m_valid = 0;
         end
      end
   endtask

   // Per-cycle compare of the default instance against the model.
   initial begin
      logic exp_rd;
      forever begin
         @(negedge clk);
         if (!rst_n) model_reset();
         exp_rd = m_fetch && (cyc >= m_rs) && (cyc < m_rs + CH);
         chk("busy", bsy, m_busy);
         chk("rom_rd_en", rd, exp_rd);
         if (exp_rd) chk("rom_addr", addr, 8'(m_fidx*CH + (cyc - m_rs)));
         chk("weights", w, exp_w(m_widx));
         chk("weights_valid", wv, m_valid);
         chk("filter_count", fc, 8'(m_count));
         chk("filter_finish", fin, m_finish);
         if (fin) fin_pulses++;
         if (rst_n) model_step(cyc + 1, start, ff);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_check_valid(input int n, inout int drops);
      for (int i = 0; i < n; i++) begin
         tick();
         if (wv !== 1'b1) drops++;
      end
   endtask

   initial begin
      int drops;
      int fin_before;
      drops = 0;

      repeat (3) tick();
      chk("reset_valid", wv, 1'b0);
      chk("reset_busy", bsy, 1'b0);
      chk("reset_count", fc, 8'd0);
      chk("reset_weights", w, 144'd0);
      rst_n = 1'b1;
      rst_aux_n = 1'b1;
      tick();

      // fmap_finish while idle does nothing
      ff = 1'b1; tick(); ff = 1'b0; tick();
      chk("ff_idle_busy", bsy, 1'b0);
      chk("ff_idle_rd", rd, 1'b0);

      // First load: start in T, reads at T+1/T+2, valid at T+4
      start = 1'b1; tick(); start = 1'b0;
      chk("first_rd_c1", {rd, addr}, {1'b1, 8'd0});
      tick();
      chk("first_rd_c2", {rd, addr}, {1'b1, 8'd1});
      tick();
      chk("first_valid_c3", wv, 1'b0);
      tick();
      chk("first_valid_c4", wv, 1'b1);
      chk("first_count", fc, 8'd0);
      chk("first_weights", w, {{9{8'h01}}, {9{8'h00}}});

      // start while busy is ignored; prefetch address stream carries on
      start = 1'b1; tick(); start = 1'b0;
      chk("busy_start_addr", {rd, addr}, {1'b1, 8'd3});
      tick();
      chk("busy_start_count", fc, 8'd0);

      // Full pass with relaxed fmap_finish spacing
      for (int k = 1; k <= 8; k++) begin
         wait_check_valid(6, drops);
         ff = 1'b1; tick(); ff = 1'b0;
         if (k < 8) begin
            if (wv !== 1'b1) drops++;
            chk("pass_count", fc, 8'(k));
         end
         if (k == 3) chk("filter3_ch1_tap0", w[79:72], 8'h07);
         if (k == 8) begin
            chk("finish_pulse", fin, 1'b1);
            chk("finish_valid", wv, 1'b0);
            chk("finish_busy", bsy, 1'b0);
         end
      end
      tick();
      chk("finish_once", fin_pulses, 1);
      chk("valid_never_drops", drops, 0);

      // Reset in the middle of fetching filter 3
      start = 1'b1; tick(); start = 1'b0;
      repeat (3) tick();
      for (int k = 0; k < 2; k++) begin
         repeat (6) tick();
         ff = 1'b1; tick(); ff = 1'b0;
      end
      chk("pre_reset_fetch", {rd, addr, fc}, {1'b1, 8'd6, 8'd2});
      fin_before = fin_pulses;
      rst_n = 1'b0;
      #1;
      chk("reset_outputs_zero", {rd, wv, fin, bsy, fc, w}, '0);
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      chk("reset_no_finish", fin_pulses, fin_before);

      // start and fmap_finish together while idle: start wins, replay from filter 0
      start = 1'b1; ff = 1'b1; tick(); start = 1'b0; ff = 1'b0;
      chk("replay_rd", {rd, addr}, {1'b1, 8'd0});
      repeat (3) tick();
      chk("replay_valid", {wv, fc}, {1'b1, 8'd0});
      chk("replay_weights", w, {{9{8'h01}}, {9{8'h00}}});

      // ROM_LAT=3: tap ordering, stall on early fmap_finish, single swap
      start3 = 1'b1; tick(); start3 = 1'b0;
      repeat (5) tick();
      chk("lat3_first_valid", {wv3, fc3}, {1'b1, 8'd0});
      chk("lat3_tap0", w3[7:0], 8'h01);
      chk("lat3_tap8", w3[71:64], 8'h09);
      chk("lat3_ch1_tap0", w3[79:72], 8'h01);
      ff3 = 1'b1; tick(); ff3 = 1'b0;
      tick();
      chk("lat3_stall", {wv3, fc3}, {1'b0, 8'd0});
      tick(); tick();
      chk("lat3_still_stalled", wv3, 1'b0);
      tick();
      chk("lat3_resume", {wv3, fc3}, {1'b1, 8'd1});
      chk("lat3_weights", w3, {rep_word(8'h03), rep_word(8'h02)});
      repeat (9) tick();
      chk("lat3_one_swap", {wv3, fc3}, {1'b1, 8'd1});

      // NUM_FILTERS=1: single load, no prefetch, one fmap_finish ends the pass
      start1 = 1'b1; tick(); start1 = 1'b0;
      repeat (3) tick();
      chk("nf1_valid", {wv1, fc1, bsy1}, {1'b1, 8'd0, 1'b1});
      chk("nf1_weights", w1, {{9{8'h01}}, {9{8'h00}}});
      tick();
      chk("nf1_no_prefetch", rd1, 1'b0);
      ff1 = 1'b1; tick(); ff1 = 1'b0;
      chk("nf1_finish", {fin1, wv1, bsy1, fc1}, {1'b1, 1'b0, 1'b0, 8'd0});
      tick();
      chk("nf1_finish_single", fin1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
